// File: rtl/multi_alarm_ctrl_if.sv
// rtl/multi_alarm_ctrl_if.sv - time, alarm setting, button and display signals of the alarm controller
interface multi_alarm_ctrl_if #(
    parameter int NUM_ALARMS = 4
) ();
    logic                    sec_tick;
    logic [4:0]              c_hour;
    logic [5:0]              c_min;
    logic [5:0]              c_sec;
    logic [5*NUM_ALARMS-1:0] a_hr;
    logic [6*NUM_ALARMS-1:0] a_min;
    logic [NUM_ALARMS-1:0]   en;
    logic                    btn_stop;
    logic                    btn_snooze;
    logic                    btn_view;
    logic                    alarm;
    logic [2:0]              alarm_id;
    logic                    snoozing;
    logic                    viewing;
    logic [3:0]              hr1;
    logic [3:0]              hr2;
    logic [3:0]              min1;
    logic [3:0]              min2;

    modport master (
        output sec_tick, c_hour, c_min, c_sec, a_hr, a_min, en,
        output btn_stop, btn_snooze, btn_view,
        input  alarm, alarm_id, snoozing, viewing, hr1, hr2, min1, min2
    );

    modport slave (
        input  sec_tick, c_hour, c_min, c_sec, a_hr, a_min, en,
        input  btn_stop, btn_snooze, btn_view,
        output alarm, alarm_id, snoozing, viewing, hr1, hr2, min1, min2
    );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// rtl/multi_alarm_ctrl.sv - multi-alarm ring/snooze controller with alarm-time view display
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_MIN  = 5,
    parameter int MAX_SNOOZE  = 3,
    parameter int VIEW_CYCLES = 100000
) (
    input logic               clk,
    input logic               rst,
    multi_alarm_ctrl_if.slave bus
);
    localparam int         VW          = $clog2(VIEW_CYCLES + 1);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    id_q, id_d;
    logic [7:0]    ring_q, ring_d;
    logic [9:0]    snz_q, snz_d;
    logic [2:0]    nsnz_q, nsnz_d;
    logic [3:0]    v_q, v_d;
    logic [VW-1:0] vt_q, vt_d;
    logic [15:0]   dig_q, dig_d;

    logic       match_any;
    logic [2:0] match_id;
    logic       en_cur;
    logic [4:0] sel_h;
    logic [5:0] sel_m;

    function automatic logic [7:0] to_bcd(input logic [5:0] val, input logic [5:0] lim);
        if (val >= lim) return 8'h99;
        return {4'(val / 6'd10), 4'(val % 6'd10)};
    endfunction

    // Scanning from the top index down leaves the lowest matching alarm as winner.
    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        en_cur    = 1'b0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (bus.en[i] && bus.sec_tick && bus.c_sec == 6'd0 &&
                bus.c_hour < 5'd24 && bus.c_min < 6'd60 &&
                bus.c_hour == bus.a_hr[5*i +: 5] && bus.c_min == bus.a_min[6*i +: 6]) begin
                match_any = 1'b1;
                match_id  = 3'(i);
            end
            if (id_q == 3'(i)) en_cur = bus.en[i];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        nsnz_d  = nsnz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (match_any) begin
                    state_d = ST_RING;
                    id_d    = match_id;
                    ring_d  = '0;
                    nsnz_d  = '0;
                end
            end
            ST_RING: begin
                if (!en_cur || bus.btn_stop) begin
                    state_d = ST_IDLE;
                end else if (bus.btn_snooze) begin
                    if (nsnz_q < 3'(MAX_SNOOZE)) begin
                        state_d = ST_SNOOZE;
                        snz_d   = SNOOZE_LOAD;
                        nsnz_d  = nsnz_q + 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.sec_tick) begin
                    ring_d = ring_q + 8'd1;
                    if (ring_d == 8'(RING_SEC)) state_d = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (!en_cur || bus.btn_stop) begin
                    state_d = ST_IDLE;
                end else if (match_any && match_id != id_q) begin
                    state_d = ST_RING;
                    id_d    = match_id;
                    ring_d  = '0;
                    nsnz_d  = '0;
                end else if (bus.sec_tick) begin
                    snz_d = snz_q - 10'd1;
                    if (snz_d == 10'd0) begin
                        state_d = ST_RING;
                        ring_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A ringing alarm overrides whatever view is selected, without disturbing it.
    always_comb begin
        v_d  = v_q;
        vt_d = vt_q;
        if (bus.btn_view) begin
            v_d  = (v_q == 4'(NUM_ALARMS)) ? 4'd0 : v_q + 4'd1;
            vt_d = VW'(VIEW_CYCLES);
        end else if (v_q != 4'd0) begin
            vt_d = vt_q - VW'(1);
            if (vt_d == '0) v_d = 4'd0;
        end

        sel_h = bus.c_hour;
        sel_m = bus.c_min;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if ((state_q == ST_RING && id_q == 3'(i)) ||
                (state_q != ST_RING && v_q == 4'(i + 1))) begin
                sel_h = bus.a_hr[5*i +: 5];
                sel_m = bus.a_min[6*i +: 6];
            end
        end
        dig_d = {to_bcd({1'b0, sel_h}, 6'd24), to_bcd(sel_m, 6'd60)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            ring_q  <= '0;
            snz_q   <= '0;
            nsnz_q  <= '0;
            v_q     <= '0;
            vt_q    <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            nsnz_q  <= nsnz_d;
            v_q     <= v_d;
            vt_q    <= vt_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.alarm    = (state_q == ST_RING);
    assign bus.snoozing = (state_q == ST_SNOOZE);
    assign bus.viewing  = (v_q != 4'd0);
    assign bus.alarm_id = id_q;
    assign bus.hr1      = dig_q[15:12];
    assign bus.hr2      = dig_q[11:8];
    assign bus.min1     = dig_q[7:4];
    assign bus.min2     = dig_q[3:0];
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb/tb_multi_alarm_ctrl.sv - directed and randomized checks of multi_alarm_ctrl against a behavioural model
module tb_multi_alarm_ctrl;
    localparam int NA = 4;
    localparam int RS = 5;
    localparam int SM = 1;
    localparam int MS = 2;
    localparam int VC = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_alarm_ctrl_if #(.NUM_ALARMS(NA)) bus ();

    multi_alarm_ctrl #(
        .NUM_ALARMS(NA), .RING_SEC(RS), .SNOOZE_MIN(SM),
        .MAX_SNOOZE(MS), .VIEW_CYCLES(VC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests;
    int fails;

    int          t_h, t_m, t_s;
    int          al_h [NA];
    int          al_m [NA];
    logic [NA-1:0] tb_en;
    bit          tick, stop, snz, view;

    // reference model: plain counters of the ring episode and the view selection
    bit          m_ringing, m_snoozed;
    int          m_id, m_ring_secs, m_snooze_left, m_snoozes, m_view, m_view_left;
    logic [15:0] m_dig;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(int v, int lim);
        if (v >= lim) return 8'h99;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [21:0] got_vec();
        return {bus.alarm, bus.alarm_id, bus.snoozing, bus.viewing,
                bus.hr1, bus.hr2, bus.min1, bus.min2};
    endfunction

    function automatic logic [21:0] exp_vec();
        return {m_ringing, 3'(m_id), m_snoozed, (m_view != 0), m_dig};
    endfunction

    task automatic model_reset();
        m_ringing = 0; m_snoozed = 0; m_id = 0; m_ring_secs = 0;
        m_snooze_left = 0; m_snoozes = 0; m_view = 0; m_view_left = 0; m_dig = '0;
    endtask

    task automatic model_step();
        int h, m, sel, win;
        bit en_cur;
        sel = m_ringing ? m_id : m_view - 1;
        if (m_ringing || m_view != 0) begin h = al_h[sel]; m = al_m[sel]; end
        else begin h = t_h; m = t_m; end
        m_dig = {bcd(h, 24), bcd(m, 60)};

        win = -1;
        if (tick && t_s == 0)
            for (int i = 0; i < NA; i++)
                if (win < 0 && tb_en[i] && t_h < 24 && t_m < 60 && al_h[i] == t_h && al_m[i] == t_m)
                    win = i;
        en_cur = tb_en[m_id];

        if (m_ringing) begin
            if (!en_cur || stop) m_ringing = 0;
            else if (snz) begin
                m_ringing = 0;
                if (m_snoozes < MS) begin
                    m_snoozed = 1; m_snooze_left = SM * 60; m_snoozes++;
                end
            end else if (tick) begin
                m_ring_secs++;
                if (m_ring_secs == RS) m_ringing = 0;
            end
        end else if (m_snoozed) begin
            if (!en_cur || stop) m_snoozed = 0;
            else if (win >= 0 && win != m_id) begin
                m_snoozed = 0; m_ringing = 1; m_id = win; m_ring_secs = 0; m_snoozes = 0;
            end else if (tick) begin
                m_snooze_left--;
                if (m_snooze_left == 0) begin m_snoozed = 0; m_ringing = 1; m_ring_secs = 0; end
            end
        end else if (win >= 0) begin
            m_ringing = 1; m_id = win; m_ring_secs = 0; m_snoozes = 0;
        end

        if (view) begin
            m_view = (m_view == NA) ? 0 : m_view + 1;
            m_view_left = VC;
        end else if (m_view != 0) begin
            m_view_left--;
            if (m_view_left == 0) m_view = 0;
        end
    endtask

    task automatic drive();
        bus.sec_tick   = tick;
        bus.c_hour     = 5'(t_h);
        bus.c_min      = 6'(t_m);
        bus.c_sec      = 6'(t_s);
        bus.en         = tb_en;
        bus.btn_stop   = stop;
        bus.btn_snooze = snz;
        bus.btn_view   = view;
        for (int i = 0; i < NA; i++) begin
            bus.a_hr[5*i +: 5]  = 5'(al_h[i]);
            bus.a_min[6*i +: 6] = 6'(al_m[i]);
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_eq("outs", 32'(got_vec()), 32'(exp_vec()));
        tick = 0; stop = 0; snz = 0; view = 0;
    endtask

    task automatic advance();
        t_s++;
        if (t_s >= 60) begin
            t_s = 0; t_m++;
            if (t_m >= 60) begin
                t_m = 0; t_h++;
                if (t_h >= 24) t_h = 0;
            end
        end
    endtask

    task automatic sec_step();
        advance();
        tick = 1;
        cycle();
    endtask

    task automatic set_time(int h, int m, int s);
        t_h = h; t_m = m; t_s = s;
    endtask

    initial begin
        bit rang;
        int r, k;
        tests = 0; fails = 0;
        tick = 0; stop = 0; snz = 0; view = 0;
        tb_en = '0;
        for (int i = 0; i < NA; i++) begin al_h[i] = 0; al_m[i] = 0; end
        set_time(7, 29, 59);
        model_reset();
        drive();
        #1;
        check_eq("reset_outs", 32'(got_vec()), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("first_digits", 32'({bus.hr1, bus.hr2, bus.min1, bus.min2}), 32'h0729);

        // single alarm rings, then auto-stops after RS ticks
        al_h[0] = 7; al_m[0] = 30; tb_en = 4'b0001;
        sec_step();
        check_eq("ring_start", 32'({bus.alarm, bus.alarm_id}), 32'b1000);
        for (int i = 1; i < RS; i++) sec_step();
        check_eq("ring_hold", 32'(bus.alarm), 32'd1);
        sec_step();
        check_eq("ring_timeout", 32'(bus.alarm), 32'd0);

        // simultaneous matches, lowest index wins; id holds in idle
        al_h[1] = 6; al_m[1] = 0; al_h[2] = 6; al_m[2] = 0; tb_en = 4'b0110;
        set_time(5, 59, 59);
        sec_step();
        check_eq("prio_id", 32'({bus.alarm, bus.alarm_id}), 32'b1001);
        stop = 1; cycle();
        check_eq("stop_id_hold", 32'({bus.alarm, bus.alarm_id}), 32'b0001);

        // snooze episodes up to the limit
        al_h[3] = 8; al_m[3] = 0; tb_en = 4'b1000;
        set_time(7, 59, 59);
        sec_step();
        check_eq("ring3", 32'({bus.alarm, bus.alarm_id}), 32'b1011);
        for (int rep = 0; rep < MS; rep++) begin
            snz = 1; cycle();
            check_eq("snoozing", 32'({bus.alarm, bus.snoozing}), 32'b01);
            for (int i = 1; i < SM * 60; i++) sec_step();
            check_eq("snooze_wait", 32'({bus.alarm, bus.snoozing}), 32'b01);
            sec_step();
            check_eq("snooze_ring", 32'({bus.alarm, bus.snoozing}), 32'b10);
        end
        snz = 1; cycle();
        check_eq("snooze_limit", 32'({bus.alarm, bus.snoozing}), 32'b00);

        // stop and snooze together
        al_h[0] = 9; al_m[0] = 0; tb_en = 4'b0001;
        set_time(8, 59, 59);
        sec_step();
        check_eq("ring0", 32'({bus.alarm, bus.alarm_id}), 32'b1000);
        stop = 1; snz = 1; cycle();
        check_eq("stop_wins", 32'({bus.alarm, bus.snoozing}), 32'b00);

        // view alarm 1, time out, then wrap
        tb_en = '0; al_h[1] = 12; al_m[1] = 5;
        set_time(10, 47, 0);
        view = 1; cycle();
        view = 1; cycle();
        check_eq("view_on", 32'(bus.viewing), 32'd1);
        cycle();
        check_eq("view_digits", 32'({bus.hr1, bus.hr2, bus.min1, bus.min2}), 32'h1205);
        for (int i = 0; i < VC - 2; i++) cycle();
        check_eq("view_before_timeout", 32'(bus.viewing), 32'd1);
        cycle();
        check_eq("view_timeout", 32'(bus.viewing), 32'd0);
        cycle();
        check_eq("view_clock", 32'({bus.hr1, bus.hr2, bus.min1, bus.min2}), 32'h1047);
        for (int i = 0; i < NA; i++) begin view = 1; cycle(); end
        check_eq("view_last", 32'(bus.viewing), 32'd1);
        view = 1; cycle();
        check_eq("view_wrap", 32'(bus.viewing), 32'd0);

        // out-of-range times
        al_h[0] = 25; al_m[0] = 10; tb_en = 4'b0001;
        set_time(25, 10, 0); tick = 1; cycle();
        check_eq("oor_nomatch", 32'(bus.alarm), 32'd0);
        cycle();
        check_eq("oor_hour", 32'({bus.hr1, bus.hr2}), 32'h99);
        t_m = 61; cycle(); cycle();
        check_eq("oor_min", 32'({bus.min1, bus.min2}), 32'h99);

        // reset while snoozing abandons the episode
        al_h[2] = 11; al_m[2] = 0; tb_en = 4'b0100;
        set_time(10, 59, 59);
        sec_step();
        check_eq("ring2", 32'({bus.alarm, bus.alarm_id}), 32'b1010);
        snz = 1; cycle();
        for (int i = 0; i < 5; i++) sec_step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_snooze", 32'(got_vec()), 32'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        rang = 0;
        for (int i = 0; i < 70; i++) begin
            sec_step();
            rang |= bus.alarm;
        end
        check_eq("no_resume", 32'(rang), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < NA; i++) begin
            al_h[i] = $urandom_range(0, 23); al_m[i] = $urandom_range(0, 59);
        end
        tb_en = '1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                k = $urandom_range(0, NA - 1);
                al_h[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
                al_m[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            end
            if ($urandom_range(0, 299) == 0) begin
                k = $urandom_range(0, NA - 1);
                tb_en[k] = ~tb_en[k];
            end
            stop = ($urandom_range(0, 59) == 0);
            snz  = ($urandom_range(0, 14) == 0);
            view = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                k = $urandom_range(0, NA - 1);
                set_time(al_h[k], al_m[k], 0);
                tick = 1;
            end else if (r < 60) begin
                advance();
                tick = 1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
